ahb_bridge_arbiter: RTL and testbench
=====================================

# ahb_bridge_arbiter

Shares the single AHB slave port of `ahb_to_apb_bridge` between up to four AHB masters. Runs a round-robin grant FSM with a burst-hold limit, muxes the owner's address/control onto the bridge, and realigns HWDATA to the data-phase owner. HREADY and HRDATA are broadcast. Sits directly in front of the bridge on the HCLK domain.

## Interface
- NUM_MASTERS, 2: requester count, legal 2..4
- MAX_HOLD, 4: accepted transfers after which a contended owner is preempted at the next legal boundary
- HCLK  in  1  system clock; all logic on rising edge
- HRESETn  in  1  asynchronous active-low reset
- HBUSREQ  in  NUM_MASTERS  per-master bus request
- HGRANT  out  NUM_MASTERS  one-hot address-phase grant; all-zero when no owner
- HADDR_M  in  NUM_MASTERS*32  flattened master addresses; master m at [32m+31:32m]
- HTRANS_M  in  NUM_MASTERS*2  flattened transfer types
- HWRITE_M  in  NUM_MASTERS  per-master write flag
- HSIZE_M  in  NUM_MASTERS*3  flattened sizes
- HWDATA_M  in  NUM_MASTERS*32  flattened write data
- HREADY  out  1  broadcast to all masters, equals HREADYOUT
- HADDR, HTRANS, HWRITE, HSIZE  out  32/2/1/3  muxed address phase to bridge
- HWDATA  out  32  muxed by data-phase owner
- HSEL  out  1  owner valid and HTRANS[1]=1
- HREADYIN  out  1  equals HREADYOUT
- HREADYOUT  in  1  bridge ready
- HRESP  in  2  bridge response; OKAY assumed, ERROR passed to masters unchanged, no arbitration effect

## Operation
- State: addr_owner (index + valid), data_owner (index + valid), last_owner, hold_cnt (saturating at MAX_HOLD).
- FSM: IDLE (no owner), OWN (owner valid). Output mux drives HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0 when in IDLE.
- All transitions only on edges with HREADYOUT=1; HREADYOUT=0 freezes every register.
- IDLE -> OWN: any HBUSREQ high; winner = first requester searching from last_owner+1 modulo NUM_MASTERS.
- OWN release: owner HTRANS=IDLE and owner HBUSREQ=0. Handover goes directly to the round-robin winner if any other request is high (no dead cycle); otherwise IDLE.
- OWN preempt: hold_cnt=MAX_HOLD, another master requesting, owner HTRANS not SEQ (2'b11) and not BUSY (2'b01). Handover as above; the current NONSEQ/IDLE is still accepted.
- Owner HBUSREQ=0 while HTRANS=SEQ/BUSY: keep grant until the burst ends.
- hold_cnt: clears on every grant change; +1 per accepted NONSEQ/SEQ from owner.
- data_owner <= addr_owner, valid only if accepted HTRANS was NONSEQ/SEQ; HWDATA = HWDATA_M[data_owner], 0 if invalid.
- last_owner updates on every new grant.

## Timing
- Reset values: HGRANT=0, HTRANS=IDLE, HSEL=0, HADDR/HWDATA=0, HWRITE=0, HSIZE=0; last_owner=NUM_MASTERS-1 so master 0 wins the first tie; hold_cnt=0.
- Request latency: HBUSREQ high sampled at edge k (HREADYOUT=1) -> HGRANT high after edge k; master NONSEQ sampled at edge k+1.
- HREADY, HREADYIN, HSEL, muxed address: combinational from registered owner and master inputs.
- HWDATA valid one accepted cycle after its address phase, tracks wait states.
- Reset asserted mid-transfer: all outputs to reset values immediately; in-flight APB transfer is the bridge's concern.
- Simultaneous requests at IDLE: round-robin order only, no fixed priority.

## Structure
- Shared header `ahb_defs.vh`: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HRESP encodings, FSM state constants.
- Sub-module `rr_pick`: combinational round-robin selector (req vector, last index -> winner index, valid); the only instance, reusable by later APB-side arbiters.

## Test plan
- Reset then HBUSREQ[0]=1, single NONSEQ write 0x10/0xA5A5A5A5 -> HGRANT=01 after one edge, bridge sees HADDR=0x10, HWDATA=0xA5A5A5A5 one cycle later.
- HBUSREQ=11 from IDLE -> master 0 granted; on release master 1 granted with no IDLE cycle; next contention grants master 0 again.
- Master 0 6-beat SEQ burst from 0x20, master 1 requesting, MAX_HOLD=4 -> no switch during SEQ beats; switch only at the first non-SEQ/BUSY boundary after 4 accepted transfers.
- PREADY=0 for 3 cycles during a master-1 write -> HREADY low, HGRANT and HWDATA held stable, no handover.
- Master 0 drops HBUSREQ mid-burst -> grant held through final SEQ; released on the next IDLE.
- HRESETn pulsed low mid-burst -> HGRANT=0, HTRANS=IDLE asynchronously; after release master 0 wins a 2-way tie.

Source files
------------

// File: rtl/ahb_bridge_arbiter_pkg.sv
// Shared AHB encodings, arbiter state type and small helpers for the
// bridge-front arbiter and its round-robin selector.
package ahb_bridge_arbiter_pkg;

  localparam int MAX_MASTERS = 4;
  localparam int IDX_W       = 2;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  function automatic logic [MAX_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after 'last',
// wrapping modulo N, with 'last' itself checked at lowest priority.
module rr_pick
  import ahb_bridge_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [MAX_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [IDX_W-1:0]       win,
  output logic                   valid
);

  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest so the nearest requester is written last.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IDX_W'((int'(last) + i) % N);
      if (req[cand]) begin
        win   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter sharing the AHB slave port of the AHB-to-APB bridge
// among up to four masters, with burst-hold preemption and HWDATA realignment.
module ahb_bridge_arbiter
  import ahb_bridge_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_HOLD    = 4
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [NUM_MASTERS-1:0]   HBUSREQ,
  output logic [NUM_MASTERS-1:0]   HGRANT,
  input  logic [NUM_MASTERS*32-1:0] HADDR_M,
  input  logic [NUM_MASTERS*2-1:0] HTRANS_M,
  input  logic [NUM_MASTERS-1:0]   HWRITE_M,
  input  logic [NUM_MASTERS*3-1:0] HSIZE_M,
  input  logic [NUM_MASTERS*32-1:0] HWDATA_M,
  output logic                     HREADY,
  output logic [31:0]              HADDR,
  output logic [1:0]               HTRANS,
  output logic                     HWRITE,
  output logic [2:0]               HSIZE,
  output logic [31:0]              HWDATA,
  output logic                     HSEL,
  output logic                     HREADYIN,
  input  logic                     HREADYOUT,
  input  logic [1:0]               HRESP
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [31:0]            addr_arr  [MAX_MASTERS];
  logic [1:0]             trans_arr [MAX_MASTERS];
  logic                   write_arr [MAX_MASTERS];
  logic [2:0]             size_arr  [MAX_MASTERS];
  logic [31:0]            wdata_arr [MAX_MASTERS];
  logic [MAX_MASTERS-1:0] req4;

  // Pad the flattened buses to four slots so a 2-bit owner index always fits.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_MASTERS; gi++) begin : g_unpack
      if (gi < NUM_MASTERS) begin : g_used
        assign addr_arr[gi]  = HADDR_M[32*gi +: 32];
        assign trans_arr[gi] = HTRANS_M[2*gi +: 2];
        assign write_arr[gi] = HWRITE_M[gi];
        assign size_arr[gi]  = HSIZE_M[3*gi +: 3];
        assign wdata_arr[gi] = HWDATA_M[32*gi +: 32];
        assign req4[gi]      = HBUSREQ[gi];
      end else begin : g_pad
        assign addr_arr[gi]  = '0;
        assign trans_arr[gi] = TRANS_IDLE;
        assign write_arr[gi] = 1'b0;
        assign size_arr[gi]  = '0;
        assign wdata_arr[gi] = '0;
        assign req4[gi]      = 1'b0;
      end
    end
  endgenerate

  arb_state_e             state_reg;
  logic [IDX_W-1:0]       owner_reg;
  logic [IDX_W-1:0]       data_owner_reg;
  logic                   data_valid_reg;
  logic [IDX_W-1:0]       last_reg;
  logic [HOLD_W-1:0]      hold_reg;
  logic [NUM_MASTERS-1:0] grant_reg;

  logic                   own;
  logic [1:0]             owner_trans;
  logic [MAX_MASTERS-1:0] owner_oh;
  logic [MAX_MASTERS-1:0] pick_req;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [MAX_MASTERS-1:0] pick_oh;
  logic                   accepted;
  logic                   release_bus;
  logic                   preempt;

  assign own         = (state_reg == ST_OWN);
  assign owner_trans = trans_arr[owner_reg];
  assign owner_oh    = onehot(owner_reg);
  assign pick_req    = own ? (req4 & ~owner_oh) : req4;
  assign pick_oh     = onehot(pick_idx);
  assign accepted    = owner_trans[1];
  assign release_bus = (owner_trans == TRANS_IDLE) && !req4[owner_reg];
  // Only NONSEQ/IDLE are legal handover points; SEQ/BUSY keep the burst intact.
  assign preempt     = (hold_reg == HOLD_W'(MAX_HOLD)) && (pick_req != '0) &&
                       (owner_trans != TRANS_SEQ) && (owner_trans != TRANS_BUSY);

  rr_pick #(.N(NUM_MASTERS)) u_rr_pick (
    .req   (pick_req),
    .last  (last_reg),
    .win   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= '0;
      data_owner_reg <= '0;
      data_valid_reg <= 1'b0;
      last_reg       <= IDX_W'(NUM_MASTERS - 1);
      hold_reg       <= '0;
      grant_reg      <= '0;
    end else if (HREADYOUT) begin
      case (state_reg)
        ST_IDLE: begin
          data_valid_reg <= 1'b0;
          if (pick_valid) begin
            state_reg <= ST_OWN;
            owner_reg <= pick_idx;
            last_reg  <= pick_idx;
            grant_reg <= pick_oh[NUM_MASTERS-1:0];
            hold_reg  <= '0;
          end
        end
        default: begin
          data_owner_reg <= owner_reg;
          data_valid_reg <= accepted;
          if (release_bus || preempt) begin
            hold_reg <= '0;
            if (pick_valid) begin
              owner_reg <= pick_idx;
              last_reg  <= pick_idx;
              grant_reg <= pick_oh[NUM_MASTERS-1:0];
            end else begin
              state_reg <= ST_IDLE;
              grant_reg <= '0;
            end
          end else if (accepted && (hold_reg != HOLD_W'(MAX_HOLD))) begin
            hold_reg <= hold_reg + HOLD_W'(1);
          end
        end
      endcase
    end
  end

  // HRESP is not an arbitration input; masters see the bridge response directly.
  logic unused_resp;
  assign unused_resp = ^HRESP;

  assign HGRANT   = grant_reg;
  assign HTRANS   = own ? owner_trans : TRANS_IDLE;
  assign HADDR    = own ? addr_arr[owner_reg] : 32'h0;
  assign HWRITE   = own ? write_arr[owner_reg] : 1'b0;
  assign HSIZE    = own ? size_arr[owner_reg] : 3'b000;
  assign HSEL     = own && owner_trans[1];
  assign HWDATA   = data_valid_reg ? wdata_arr[data_owner_reg] : 32'h0;
  assign HREADY   = HREADYOUT;
  assign HREADYIN = HREADYOUT;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed plus randomized bench for ahb_bridge_arbiter, checked against an
// owner/hold/round-robin reference model kept in plain integers.
module tb_ahb_bridge_arbiter;

  localparam int NM = 3;
  localparam int MH = 4;

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic [NM-1:0]     HBUSREQ;
  logic [NM-1:0]     HGRANT;
  logic [NM*32-1:0]  HADDR_M;
  logic [NM*2-1:0]   HTRANS_M;
  logic [NM-1:0]     HWRITE_M;
  logic [NM*3-1:0]   HSIZE_M;
  logic [NM*32-1:0]  HWDATA_M;
  logic              HREADY;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HSEL;
  logic              HREADYIN;
  logic              HREADYOUT;
  logic [1:0]        HRESP;

  logic [31:0] t_addr  [NM];
  logic [1:0]  t_trans [NM];
  logic        t_write [NM];
  logic [2:0]  t_size  [NM];
  logic [31:0] t_wdata [NM];
  logic [NM-1:0] t_req;
  logic        t_rdy;

  int total = 0;
  int bad = 0;
  int m_owner, m_downer, m_last, m_hold;

  always #5 HCLK = ~HCLK;

  always_comb begin
    for (int m = 0; m < NM; m++) begin
      HADDR_M[32*m +: 32] = t_addr[m];
      HTRANS_M[2*m +: 2]  = t_trans[m];
      HWRITE_M[m]         = t_write[m];
      HSIZE_M[3*m +: 3]   = t_size[m];
      HWDATA_M[32*m +: 32] = t_wdata[m];
    end
  end
  assign HBUSREQ   = t_req;
  assign HREADYOUT = t_rdy;
  assign HRESP     = 2'b00;

  ahb_bridge_arbiter #(.NUM_MASTERS(NM), .MAX_HOLD(MH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HGRANT(HGRANT),
    .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M),
    .HSIZE_M(HSIZE_M), .HWDATA_M(HWDATA_M), .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HSEL(HSEL), .HREADYIN(HREADYIN),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  function automatic int rr_win(input logic [NM-1:0] req, input int last, input int excl);
    int c;
    for (int k = 1; k <= NM; k++) begin
      c = (last + k) % NM;
      if (c != excl && req[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_downer = -1;
    m_last   = NM - 1;
    m_hold   = 0;
  endtask

  // One accepted bus edge as described by the arbitration rules.
  task automatic model_edge();
    logic [1:0] t;
    bit acc, others, rel, pre;
    int w;
    if (!t_rdy) return;
    if (m_owner < 0) begin
      m_downer = -1;
      w = rr_win(t_req, m_last, -1);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_hold  = 0;
      end
    end else begin
      t = t_trans[m_owner[1:0]];
      acc = (t == 2'b10) || (t == 2'b11);
      m_downer = acc ? m_owner : -1;
      others = 1'b0;
      for (int j = 0; j < NM; j++)
        if (j != m_owner && t_req[j[1:0]]) others = 1'b1;
      rel = (t == 2'b00) && !t_req[m_owner[1:0]];
      pre = (m_hold == MH) && others && (t != 2'b11) && (t != 2'b01);
      if (rel || pre) begin
        w = rr_win(t_req, m_last, m_owner);
        m_owner = w;
        if (w >= 0) m_last = w;
        m_hold = 0;
      end else if (acc && m_hold < MH) begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_grant, e_addr, e_wdata;
    logic [1:0]  e_trans;
    logic        e_write, e_sel;
    logic [2:0]  e_size;
    #1;
    e_grant = 32'h0; e_addr = 32'h0; e_trans = 2'b00; e_write = 1'b0; e_size = 3'b0;
    if (m_owner >= 0) begin
      e_grant = 32'h1 << m_owner;
      e_addr  = t_addr[m_owner[1:0]];
      e_trans = t_trans[m_owner[1:0]];
      e_write = t_write[m_owner[1:0]];
      e_size  = t_size[m_owner[1:0]];
    end
    e_sel   = (m_owner >= 0) && e_trans[1];
    e_wdata = (m_downer >= 0) ? t_wdata[m_downer[1:0]] : 32'h0;
    chk({tag, ".grant"}, 32'(HGRANT), e_grant);
    chk({tag, ".htrans"}, 32'(HTRANS), 32'(e_trans));
    chk({tag, ".haddr"}, HADDR, e_addr);
    chk({tag, ".hwrite"}, 32'(HWRITE), 32'(e_write));
    chk({tag, ".hsize"}, 32'(HSIZE), 32'(e_size));
    chk({tag, ".hsel"}, 32'(HSEL), 32'(e_sel));
    chk({tag, ".hwdata"}, HWDATA, e_wdata);
    chk({tag, ".hready"}, 32'(HREADY), 32'(t_rdy));
    chk({tag, ".hreadyin"}, 32'(HREADYIN), 32'(t_rdy));
    $display("%0t %s grant=%b trans=%0d addr=%h wdata=%h rdy=%b", $time, tag,
             HGRANT, HTRANS, HADDR, HWDATA, HREADY);
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < NM; m++) begin
      t_addr[m] = 32'h0; t_trans[m] = 2'b00; t_write[m] = 1'b0;
      t_size[m] = 3'b010; t_wdata[m] = 32'h0;
    end
    t_req = '0;
    t_rdy = 1'b1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    model_reset();
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    @(posedge HCLK);
    #1;
    check_all("reset");
    HRESETn = 1'b1;

    // Single NONSEQ write from master 0.
    t_req = 3'b001;
    check_all("t1_req");
    tick();
    check_all("t1_grant");
    chk("t1_grant_const", 32'(HGRANT), 32'h1);
    t_trans[0] = 2'b10; t_addr[0] = 32'h10; t_write[0] = 1'b1;
    check_all("t1_addr");
    chk("t1_haddr_const", HADDR, 32'h10);
    tick();
    t_trans[0] = 2'b00; t_req = 3'b000; t_wdata[0] = 32'hA5A5A5A5;
    check_all("t1_data");
    chk("t1_hwdata_const", HWDATA, 32'hA5A5A5A5);
    tick();
    check_all("t1_release");
    chk("t1_idle_const", 32'(HGRANT), 32'h0);

    // Two-way contention from reset: 0 first, then 1 without a dead cycle.
    do_reset();
    t_req = 3'b011;
    tick();
    check_all("t2_first");
    chk("t2_first_const", 32'(HGRANT), 32'h1);
    t_trans[0] = 2'b10; t_addr[0] = 32'h14;
    tick();
    check_all("t2_beat");
    t_trans[0] = 2'b00; t_req = 3'b010;
    tick();
    check_all("t2_handover");
    chk("t2_handover_const", 32'(HGRANT), 32'h2);
    t_req = 3'b001; t_trans[1] = 2'b00;
    tick();
    check_all("t2_back");
    chk("t2_back_const", 32'(HGRANT), 32'h1);

    // 6-beat burst with master 1 waiting: preempt only after the burst.
    t_req = 3'b011;
    for (int b = 0; b < 6; b++) begin
      t_trans[0] = (b == 0) ? 2'b10 : 2'b11;
      t_addr[0]  = 32'h20 + 32'(4 * b);
      t_wdata[0] = 32'h1000 + 32'(b);
      check_all("t3_burst");
      tick();
      chk("t3_hold_const", 32'(HGRANT), 32'h1);
    end
    t_trans[0] = 2'b10; t_addr[0] = 32'h38;
    check_all("t3_boundary");
    tick();
    check_all("t3_switch");
    chk("t3_switch_const", 32'(HGRANT), 32'h2);

    // Wait states during a master-1 write freeze grant and data.
    t_req = 3'b010; t_trans[0] = 2'b00;
    t_trans[1] = 2'b10; t_addr[1] = 32'h40; t_write[1] = 1'b1;
    check_all("t4_addr");
    tick();
    t_rdy = 1'b0; t_trans[1] = 2'b00; t_req = 3'b001; t_wdata[1] = 32'h00001234;
    for (int w = 0; w < 3; w++) begin
      check_all("t4_wait");
      chk("t4_wait_grant", 32'(HGRANT), 32'h2);
      chk("t4_wait_data", HWDATA, 32'h00001234);
      tick();
    end
    t_rdy = 1'b1;
    check_all("t4_ready");
    tick();
    check_all("t4_release");
    chk("t4_release_const", 32'(HGRANT), 32'h1);

    // Master 0 drops its request mid-burst; grant lasts to the IDLE.
    t_req = 3'b001;
    for (int b = 0; b < 4; b++) begin
      t_trans[0] = (b == 0) ? 2'b10 : 2'b11;
      t_addr[0]  = 32'h80 + 32'(4 * b);
      if (b == 1) t_req = 3'b000;
      check_all("t5_burst");
      tick();
      chk("t5_hold_const", 32'(HGRANT), 32'h1);
    end
    t_trans[0] = 2'b00;
    check_all("t5_end");
    tick();
    check_all("t5_release");
    chk("t5_release_const", 32'(HGRANT), 32'h0);

    // Asynchronous reset in the middle of a burst.
    t_req = 3'b001;
    tick();
    t_trans[0] = 2'b10; t_addr[0] = 32'h100;
    tick();
    t_trans[0] = 2'b11; t_addr[0] = 32'h104;
    check_all("t6_burst");
    #2;
    HRESETn = 1'b0;
    model_reset();
    #1;
    chk("t6_async_grant", 32'(HGRANT), 32'h0);
    chk("t6_async_trans", 32'(HTRANS), 32'h0);
    check_all("t6_in_reset");
    t_trans[0] = 2'b00; t_req = 3'b000;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    t_req = 3'b011;
    check_all("t6_released");
    tick();
    check_all("t6_tie");
    chk("t6_tie_const", 32'(HGRANT), 32'h1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < NM; m++) begin
        t_req[m]   = ($urandom_range(0, 2) != 0);
        t_trans[m] = 2'($urandom_range(0, 3));
        t_addr[m]  = $urandom;
        t_write[m] = 1'($urandom_range(0, 1));
        t_size[m]  = 3'($urandom_range(0, 7));
        t_wdata[m] = $urandom;
      end
      t_rdy = ($urandom_range(0, 3) != 0);
      check_all("rand");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
